// File: rtl/core_pkg.sv
// Shared types and size helpers for the core memory access path.
package core_pkg;

  typedef enum logic [2:0] {
    SIZE_B  = 3'd0,
    SIZE_BU = 3'd1,
    SIZE_H  = 3'd2,
    SIZE_HU = 3'd3,
    SIZE_W  = 3'd4
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    RSP0 = 3'd2,
    REQ1 = 3'd3,
    RSP1 = 3'd4,
    RESP = 3'd5
  } split_state_e;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] size_nbytes(input mem_size_e s);
    case (s)
      SIZE_H, SIZE_HU: size_nbytes = 3'd2;
      SIZE_W:          size_nbytes = 3'd4;
      default:         size_nbytes = 3'd1;
    endcase
  endfunction

  // Loads of this size are sign-extended.
  function automatic logic size_signed(input mem_size_e s);
    case (s)
      SIZE_B, SIZE_H: size_signed = 1'b1;
      default:        size_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_load_align.sv
// Load data merge: shifts the two-beat read window down to the access
// offset, truncates to the access size and sign/zero-extends.
module core_load_align
  import core_pkg::*;
(
  input  logic [31:0] i_rdata1,
  input  logic [31:0] i_rdata0,
  input  logic [1:0]  i_off,
  input  mem_size_e   i_size,
  output logic [31:0] o_value
);

  logic [31:0] w_shifted;
  logic        w_signed;

  assign w_shifted = 32'({i_rdata1, i_rdata0} >> {i_off, 3'b000});
  assign w_signed  = size_signed(i_size);

  // Truncate to the access width and extend to 32 bits.
  always_comb begin
    o_value = w_shifted;
    case (size_nbytes(i_size))
      3'd1: o_value = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
      3'd2: o_value = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: o_value = w_shifted;
    endcase
  end

endmodule

// File: rtl/core_misaligned_split.sv
// Misaligned access splitter: turns one byte/half/word access at any byte
// address into one or two word-aligned bus beats and returns one response.
module core_misaligned_split
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  mem_size_e       req_size,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_error,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic [XLEN-1:0] bus_addr,
  output logic            bus_write,
  output logic [3:0]      bus_wstrb,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_rerror
);

  split_state_e r_state;
  split_state_e w_next;

  logic [31:0] r_addr;
  mem_size_e   r_size;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic        r_error;

  logic [1:0]  w_off;
  logic [2:0]  w_nbytes;
  logic        w_split;
  logic [7:0]  w_mask8;
  logic [7:0]  w_strb8;
  logic [63:0] w_wdata64;
  logic [31:0] w_beat0_addr;
  logic [31:0] w_beat1_addr;
  logic [31:0] w_rdata1_eff;
  logic [31:0] w_load;

  assign w_off        = r_addr[1:0];
  assign w_nbytes     = size_nbytes(r_size);
  assign w_split      = ({2'b00, w_off} + {1'b0, w_nbytes}) > 4'd4;
  assign w_mask8      = (8'd1 << w_nbytes) - 8'd1;
  assign w_strb8      = w_mask8 << w_off;
  assign w_wdata64    = {32'b0, r_wdata} << {w_off, 3'b000};
  assign w_beat0_addr = {r_addr[31:2], 2'b00};
  assign w_beat1_addr = w_beat0_addr + 32'd4;
  assign w_rdata1_eff = w_split ? r_rdata1 : '0;

  core_load_align u_load_align (
    .i_rdata1 (w_rdata1_eff),
    .i_rdata0 (r_rdata0),
    .i_off    (w_off),
    .i_size   (r_size),
    .o_value  (w_load)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Request capture and per-beat read data / error latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_size   <= SIZE_B;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_addr   <= req_addr;
          r_size   <= req_size;
          r_write  <= req_write;
          r_wdata  <= req_wdata;
          r_rdata0 <= '0;
          r_rdata1 <= '0;
          r_error  <= 1'b0;
        end
        RSP0: if (bus_rvalid) begin
          r_error <= bus_rerror;
          if (!bus_rerror) r_rdata0 <= bus_rdata;
        end
        RSP1: if (bus_rvalid) begin
          r_error <= bus_rerror;
          if (!bus_rerror) r_rdata1 <= bus_rdata;
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode; outputs are zero outside their states.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    bus_valid  = 1'b0;
    bus_addr   = '0;
    bus_write  = 1'b0;
    bus_wstrb  = '0;
    bus_wdata  = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_error = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = REQ0;
      end
      REQ0: begin
        bus_valid = 1'b1;
        bus_addr  = w_beat0_addr;
        bus_write = r_write;
        bus_wstrb = w_strb8[3:0];
        bus_wdata = w_wdata64[31:0];
        if (bus_ready) w_next = RSP0;
      end
      RSP0: begin
        if (bus_rvalid) begin
          if (bus_rerror)   w_next = RESP;
          else if (w_split) w_next = REQ1;
          else              w_next = RESP;
        end
      end
      REQ1: begin
        bus_valid = 1'b1;
        bus_addr  = w_beat1_addr;
        bus_write = r_write;
        bus_wstrb = w_strb8[7:4];
        bus_wdata = w_wdata64[63:32];
        if (bus_ready) w_next = RSP1;
      end
      RSP1: begin
        if (bus_rvalid) w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_error = r_error;
        resp_rdata = (r_write || r_error) ? '0 : w_load;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
